// File: rtl/updown_counter_pkg.sv
// Shared types and the tick arithmetic for the up/down event counter.
package updown_counter_pkg;

   typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} cnt_mode_t;

   // Wide enough for a 32-bit count plus the carry bit used in the range check.
   localparam int CALC_W = 33;

   typedef struct packed {
      logic [CALC_W-1:0] next;
      logic              evt;
   } step_result_t;

   // Next count and boundary-event flag for one tick. Operands are zero-extended
   // so the sum is never truncated before it is compared with max_val.
   function automatic step_result_t calc_next(input logic [CALC_W-1:0] cnt,
                                              input logic [CALC_W-1:0] stp,
                                              input logic              up,
                                              input cnt_mode_t         mode,
                                              input logic [CALC_W-1:0] max_val);
      step_result_t      res;
      logic [CALC_W-1:0] r;
      res.next = cnt;
      res.evt  = 1'b0;
      r        = cnt + stp;
      if (up) begin
         if (r > max_val) begin
            res.evt  = 1'b1;
            res.next = (mode == MODE_SAT) ? max_val : r - (max_val + 1'b1);
         end else begin
            res.next = r;
         end
      end else begin
         if (stp > cnt) begin
            res.evt  = 1'b1;
            res.next = (mode == MODE_SAT) ? '0 : cnt + (max_val + 1'b1) - stp;
         end else begin
            res.next = cnt - stp;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/updown_counter_mod_prescaler.sv
// Divides enabled cycles down to counting ticks; tick is high on the enabled
// cycle that completes a PRESCALE-long group.
module counter_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   generate
      if (PRESCALE == 1) begin : g_direct
         logic unused_in;
         assign unused_in = ^{clk, rst, clr};
         assign tick      = en;
      end else begin : g_div
         localparam int PW = $clog2(PRESCALE);
         localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
         logic [PW-1:0] phase;

         assign tick = en && (phase == LAST);

         // Phase advances only while enabled; load and reset restart the group.
         always_ff @(posedge clk) begin
            if (rst || clr) begin
               phase <= '0;
            end else if (en) begin
               phase <= (phase == LAST) ? '0 : phase + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/updown_counter_mod.sv
// General-purpose up/down event counter with modulo limit, variable step,
// wrap/saturate mode, prescaler, terminal-count pulse and sticky overflow.
module updown_counter_mod
   import updown_counter_pkg::*;
#(
   parameter int          WIDTH    = 8,
   parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
   parameter int          STEP_W   = 4,
   parameter int          PRESCALE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              updown,
   input  logic [STEP_W-1:0] step,
   input  logic              mode,
   input  logic              clr_ovf,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              ovf,
   output logic              zero
);

   logic         tick;
   step_result_t nxt;
   logic [WIDTH-1:0] load_clamped;
   logic         unused_hi;

   counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (load),
      .en   (en),
      .tick (tick)
   );

   // Candidate next count for a tick, evaluated from the registered count.
   always_comb begin
      nxt = calc_next(CALC_W'(count), CALC_W'(step), updown, cnt_mode_t'(mode),
                      CALC_W'(MAX_VAL));
   end

   // Loaded values above the limit are clamped to it.
   always_comb begin
      load_clamped = (CALC_W'(load_val) > CALC_W'(MAX_VAL)) ? WIDTH'(MAX_VAL) : load_val;
   end

   // The result never exceeds MAX_VAL, so the upper bits are always zero.
   assign unused_hi = ^nxt.next[CALC_W-1:WIDTH];

   // Priority rst > load > tick > hold; a boundary event sets ovf over clr_ovf.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else if (load) begin
         count <= load_clamped;
         tc    <= 1'b0;
         if (clr_ovf) ovf <= 1'b0;
      end else if (tick) begin
         count <= WIDTH'(nxt.next);
         tc    <= nxt.evt;
         if (nxt.evt)      ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (clr_ovf) ovf <= 1'b0;
      end
   end

   assign zero = (count == '0);

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised successor to the team's 4-bit load/up/down counter. It adds:
- configurable width and modulo limit,
- a variable step size,
- selectable wrap or saturate behaviour,
- a built-in prescaler,
- a terminal-count pulse and a sticky overflow flag.

It is intended as the general-purpose event/timer counter for the design, feeding interrupt and status logic.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2).
- MAX_VAL, 2**WIDTH-1, highest legal count. Range is 0..MAX_VAL.
- STEP_W, 4, width of step input (STEP_W ≤ WIDTH).
- PRESCALE, 1, number of enabled cycles per counting tick (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable; low freezes counter and prescaler.
- load  in  1  load count from load_val.
- load_val  in  WIDTH  value to load.
- updown  in  1  1 = count up, 0 = count down.
- step  in  STEP_W  increment/decrement amount per tick.
- mode  in  1  0 = wrap (modulo MAX_VAL+1), 1 = saturate.
- clr_ovf  in  1  clears sticky overflow flag.
- count  out  WIDTH  current count.
- tc  out  1  one-cycle terminal-count pulse.
- ovf  out  1  sticky boundary-event flag.
- zero  out  1  count == 0 (combinational from register).

## Operation
Priority per edge: rst > load > tick > hold.
- rst: count=0, tc=0, ovf=0, prescaler=0.
- load: count = min(load_val, MAX_VAL).
  - Prescaler cleared; tc=0.
  - ovf unaffected unless clr_ovf.
- Tick:
  - Asserted when en=1 and prescaler == PRESCALE-1. Prescaler then returns to 0; otherwise it increments while en=1.
  - PRESCALE=1 means tick on every enabled cycle.
- Arithmetic on a tick uses WIDTH+1 bits, unsigned; no truncation before the range check.
  - Up: r = count + step. If r > MAX_VAL it is a boundary event:
    - wrap: count = r - (MAX_VAL+1).
    - sat: count = MAX_VAL.
  - Down: if step > count it is a boundary event:
    - wrap: count = count + (MAX_VAL+1) - step.
    - sat: count = 0.
  - Otherwise count = r (up) or count - step (down).
  - step = 0: count holds, no event.
  - step > MAX_VAL is illegal; behaviour is undefined and the bench must not drive it.
- Boundary event: tc=1 on that edge, ovf=1.
  - In saturate mode, every tick attempting to pass the limit is an event, so tc repeats each tick while pinned.
- tc is 0 on every edge without a boundary event.
- ovf:
  - clr_ovf alone clears it.
  - If a boundary event and clr_ovf occur on the same edge, set wins.
- updown, step and mode are sampled only on tick edges. Changing them between ticks has no effect until the next tick.
- rst mid-count overrides everything, including a pending tick; counting resumes from 0 with a fresh prescaler phase.

## Timing
- count, tc and ovf are registered; they change on the edge where the tick/load/rst is sampled.
- tc is high for exactly one clock after a boundary-event edge, coincident with the new count.
- zero has zero latency from count.
- Latency from en rising to the first tick is PRESCALE edges.
- After load, the first tick comes PRESCALE enabled edges later.
- No combinational path from any input to any output.

## Structure
- Package updown_counter_pkg:
  - typedef enum logic {MODE_WRAP=1'b0, MODE_SAT=1'b1} cnt_mode_t.
  - Helper function computing next count and event flag from (count, step, updown, mode, MAX_VAL).
- Sub-module counter_prescaler:
  - Parameter PRESCALE.
  - Ports clk, rst, clr, en, tick.
  - Contains a $clog2(PRESCALE)-bit counter.
  - Ties tick=en when PRESCALE=1.
- Top level holds the count register, tc/ovf registers and priority logic.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9, STEP_W=4, PRESCALE=1 unless noted.
- Reset: assert rst with en=1 and load=1 for 2 cycles → count=0, tc=0, ovf=0, zero=1 after the first edge.
- Wrap up: load 8, mode=0, updown=1, step=1, en=1 → count 9, then 0 with tc=1 and ovf=1, then 1 with tc=0.
- Saturate down: load 2, mode=1, updown=0, step=3 → count 0 with tc=1, next tick count stays 0 with tc=1 again. clr_ovf with no event clears ovf.
- Load clamp and priority:
  - load_val=15 → count=9.
  - load=1, load_val=4 on the same edge as a tick → count=4, tc=0.
  - clr_ovf on the same edge as a wrap → ovf stays 1.
- Prescaler (PRESCALE=3): en=1, up, step=2 from 0 → count 2 after edge 3, 4 after edge 6. Dropping en for 5 cycles holds count and prescaler phase.
- Wrap down with step: count=1, step=4, mode=0, updown=0 → count 7, tc=1.
